alu24_op_sequencer: RTL

//  Issues operations to the 24-bit ALU for a single requester over a valid/ready command channel.

---
 rtl/alu24_op_sequencer.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/alu24_op_sequencer.sv
// alu24_op_sequencer: issues commands from one requester to a 24-bit ALU.
// Single ALU ops take one EXEC cycle and are registered. MUL is an unsigned
// shift-and-add loop that reuses the ALU adder, one ALU add per step.
// The result is held in DONE until the consumer takes it.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// 1. Valid must not depend on ready. A source holds its payload stable while
// valid & ~ready. ReqReady is high only in IDLE with Reset low. RspValid is
// high only in DONE. IDLE and DONE are distinct states, so a command is never
// accepted in the same cycle as a response handshake.
//
// Optional feature: define ALU24_SEQ_EARLY_EXIT_EN to leave the MUL loop as
// soon as the remaining multiplier is zero. Results and flags are the same as
// the full 24-step loop.
module alu24_op_sequencer #(
  parameter int WIDTH     = 24,
  parameter int MUL_STEPS = 24
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic             ReqMul,
  input  logic [2:0]       ReqOp,
  input  logic             ReqBNegate,
  input  logic [WIDTH-1:0] ReqA,
  input  logic [WIDTH-1:0] ReqB,
  input  logic [3:0]       ReqShamt,
  output logic             RspValid,
  input  logic             RspReady,
  output logic [WIDTH-1:0] RspResult,
  output logic             RspZero,
  output logic             RspOverflow,
  output logic             RspCarry,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  output logic [3:0]       AluShamt,
  output logic             AluBNegate,
  output logic [2:0]       AluOp,
  input  logic [WIDTH-1:0] AluResult,
  input  logic             AluZero,
  input  logic             AluOverflow,
  input  logic             AluCarry,
  output logic [1:0]       dbg_state
);

  localparam int STEP_W = $clog2(MUL_STEPS + 1);
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_ZERO = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic               bneg_q, bneg_d;
  logic [3:0]         shamt_q, shamt_d;
  // a_q holds operand A, which is the multiplicand during MUL (shifted left).
  // b_q holds operand B, which is the multiplier during MUL (shifted right).
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
  logic               rsp_zero_q, rsp_zero_d;
  logic               rsp_ovf_q, rsp_ovf_d;
  logic               rsp_carry_q, rsp_carry_d;
  logic               mul_done;

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      bneg_q       <= 1'b0;
      shamt_q      <= '0;
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      step_q       <= '0;
      ovf_q        <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_carry_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      bneg_q       <= bneg_d;
      shamt_q      <= shamt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      acc_q        <= acc_d;
      step_q       <= step_d;
      ovf_q        <= ovf_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_carry_q  <= rsp_carry_d;
    end
  end

  // Next-state and datapath update: command latch, MUL step, result capture.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    bneg_d       = bneg_q;
    shamt_d      = shamt_q;
    a_d          = a_q;
    b_d          = b_q;
    acc_d        = acc_q;
    step_d       = step_q;
    ovf_d        = ovf_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_carry_d  = rsp_carry_q;
    // The loop always ends after MUL_STEPS steps. With early exit it can also
    // end as soon as no multiplier bits remain.
`ifdef ALU24_SEQ_EARLY_EXIT_EN
    mul_done = (step_q == STEP_W'(MUL_STEPS)) || (b_q == '0);
`else
    mul_done = (step_q == STEP_W'(MUL_STEPS));
`endif
    case (state_q)
      ST_IDLE: begin
        if (ReqValid && ReqReady) begin
          op_d    = ReqOp;
          bneg_d  = ReqBNegate;
          shamt_d = ReqShamt;
          a_d     = ReqA;
          b_d     = ReqB;
          if (ReqMul) begin
            acc_d   = '0;
            step_d  = '0;
            ovf_d   = 1'b0;
            state_d = ST_MUL;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        rsp_result_d = AluResult;
        rsp_zero_d   = AluZero;
        rsp_ovf_d    = AluOverflow;
        rsp_carry_d  = AluCarry;
        state_d      = ST_DONE;
      end
      ST_MUL: begin
        if (mul_done) begin
          rsp_result_d = acc_q;
          rsp_zero_d   = (acc_q == '0);
          rsp_ovf_d    = ovf_q;
          rsp_carry_d  = 1'b0;
          state_d      = ST_DONE;
        end else begin
          if (b_q[0]) begin
            acc_d = AluResult;
            ovf_d = ovf_q | AluCarry;
          end
          // A multiplicand bit about to be shifted out while higher multiplier
          // bits remain would add 2^WIDTH or more to the product.
          ovf_d  = ovf_d | (a_q[WIDTH-1] & (|b_q[WIDTH-1:1]));
          a_d    = a_q << 1;
          b_d    = b_q >> 1;
          step_d = step_q + STEP_W'(1);
        end
      end
      ST_DONE: begin
        if (RspReady) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: ALU operands per state and handshake and response signals.
  always_comb begin
    AluA       = '0;
    AluB       = '0;
    AluShamt   = '0;
    AluBNegate = 1'b0;
    AluOp      = OP_ZERO;
    case (state_q)
      ST_EXEC: begin
        AluA       = a_q;
        AluB       = b_q;
        AluShamt   = shamt_q;
        AluBNegate = bneg_q;
        AluOp      = op_q;
      end
      ST_MUL: begin
        AluA  = acc_q;
        AluB  = a_q;
        AluOp = OP_ADD;
      end
      default: ;
    endcase
    ReqReady    = (state_q == ST_IDLE) && !Reset;
    RspValid    = (state_q == ST_DONE);
    RspResult   = rsp_result_q;
    RspZero     = rsp_zero_q;
    RspOverflow = rsp_ovf_q;
    RspCarry    = rsp_carry_q;
    dbg_state   = state_q;
  end

endmodule
